// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the nibble-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// 4-bit full-adder slice (74AC283 equivalent): o_s/o_co = i_a + i_b + i_ci.
module nibble_add4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);

    assign {o_co, o_s} = 5'(i_a) + 5'(i_b) + 5'(i_ci);

endmodule

// File: rtl/serial_sub4.sv
// Nibble-serial subtractor y = a - b using one reused 4-bit adder slice.
// Define SERIAL_SUB4_ADD_EN to add an op port selecting add (op=1) or subtract.
module serial_sub4
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB4_ADD_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             borrow
);

    localparam int unsigned NIB   = nib_count(WIDTH);
    localparam int unsigned CNT_W = $clog2(NIB);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("serial_sub4: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_sb_init;
    logic             w_ci_init;
    logic             w_last_out;
    logic [3:0]       w_sum;
    logic             w_co;

`ifdef SERIAL_SUB4_ADD_EN
    logic r_add;

    assign w_sb_init  = op ? b : ~b;
    assign w_ci_init  = ~op;
    assign w_last_out = r_add ? w_co : ~w_co;
`else
    assign w_sb_init  = ~b;
    assign w_ci_init  = 1'b1;
    assign w_last_out = ~w_co;
`endif

    nibble_add4 u_slice (
        .i_a  (r_sa[3:0]),
        .i_b  (r_sb[3:0]),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // Control FSM plus operand/result shift datapath; accept is legal in IDLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_SUB4_ADD_EN
            r_add    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= w_sb_init;
                        r_carry <= w_ci_init;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
`ifdef SERIAL_SUB4_ADD_EN
                        r_add   <= op;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_y     <= {w_sum, r_y[WIDTH-1:NIBBLE_W]};
                    r_sa    <= r_sa >> NIBBLE_W;
                    r_sb    <= r_sb >> NIBBLE_W;
                    r_carry <= w_co;
                    if (r_cnt == CNT_W'(NIB - 1)) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_borrow <= w_last_out;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign y      = r_y;
    assign borrow = r_borrow;

endmodule
